// File: rtl/pbru_in_arb.sv
// Input arbiter: grants one requester channel at a time and streams its beats
// to the aggregator, switching channels only on wide-word boundaries.
module pbru_in_arb #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned INPUT_WIDTH  = 16,
   parameter int unsigned SET_NUMBER   = 64,
   parameter int unsigned WEIGHT_WIDTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_CH-1:0]                    i_ch_valid,
   input  logic [NUM_CH*INPUT_WIDTH-1:0]        i_ch_data,
   output logic [NUM_CH-1:0]                    o_ch_ready,
   input  logic                                 i_cfg_enable,
   input  logic                                 i_cfg_mode,
   input  logic [NUM_CH*WEIGHT_WIDTH-1:0]       i_cfg_weight,
   input  logic                                 i_agg_full,
   output logic                                 o_agg_wr_valid,
   output logic [INPUT_WIDTH-1:0]               o_agg_data,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_grant_id,
   output logic                                 o_busy
);

   localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned BW = (SET_NUMBER > 1) ? $clog2(SET_NUMBER) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARB   = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   state_e                  state_q;
   logic [GW-1:0]           grant_q;
   logic [GW-1:0]           rr_ptr_q;
   logic [BW-1:0]           beat_q;
   logic [WEIGHT_WIDTH-1:0] word_q;
   logic [WEIGHT_WIDTH-1:0] quota_q;

   logic [NUM_CH-1:0]       elig_req_c;
   logic                    win_found_c;
   logic [GW-1:0]           win_id_c;
   logic [WEIGHT_WIDTH-1:0] win_weight_c;
   logic                    in_burst_c;
   logic                    gnt_valid_c;
   logic [INPUT_WIDTH-1:0]  gnt_data_c;
   logic                    xfer_c;
   logic                    beat_last_c;
   logic [WEIGHT_WIDTH-1:0] word_nxt_c;
   logic [GW-1:0]           ptr_nxt_c;

   // Requests that may compete: zero-weight channels sit out in weighted mode.
   always_comb begin
      elig_req_c = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (!i_cfg_mode || (i_cfg_weight[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0)) begin
            elig_req_c[c] = i_ch_valid[c];
         end
      end
   end

   // First eligible requester at or after rr_ptr, wrapping around.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      win_found_c = 1'b0;
      win_id_c    = rr_ptr_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (!win_found_c && elig_req_c[GW'(idx)]) begin
            win_found_c = 1'b1;
            win_id_c    = GW'(idx);
         end
      end
   end

   assign win_weight_c = i_cfg_weight[int'(win_id_c)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

   assign in_burst_c  = (state_q == ST_BURST);
   assign gnt_valid_c = i_ch_valid[grant_q];
   assign gnt_data_c  = i_ch_data[int'(grant_q)*INPUT_WIDTH +: INPUT_WIDTH];
   assign xfer_c      = in_burst_c && gnt_valid_c && !i_agg_full;
   assign beat_last_c = (beat_q == BW'(SET_NUMBER - 1));
   assign word_nxt_c  = word_q + WEIGHT_WIDTH'(1);
   assign ptr_nxt_c   = (grant_q == GW'(NUM_CH - 1)) ? '0 : grant_q + GW'(1);

   // Only the granted channel is offered ready, and only while the aggregator has room.
   always_comb begin
      o_ch_ready = '0;
      if (in_burst_c && !i_agg_full) begin
         o_ch_ready[grant_q] = 1'b1;
      end
   end

   assign o_agg_wr_valid = xfer_c;
   assign o_agg_data     = in_burst_c ? gnt_data_c : '0;
   assign o_grant_id     = grant_q;
   assign o_busy         = (state_q != ST_IDLE);

   // Scheduler state, grant and beat/word counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         beat_q   <= '0;
         word_q   <= '0;
         quota_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_cfg_enable && (|elig_req_c)) begin
                  state_q <= ST_ARB;
               end
            end
            ST_ARB: begin
               if (win_found_c) begin
                  grant_q <= win_id_c;
                  quota_q <= i_cfg_mode ? win_weight_c : WEIGHT_WIDTH'(1);
                  beat_q  <= '0;
                  word_q  <= '0;
                  state_q <= ST_BURST;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_BURST: begin
               if (xfer_c) begin
                  if (beat_last_c) begin
                     beat_q <= '0;
                     word_q <= word_nxt_c;
                     // Grant may end only here, after a complete wide word.
                     if (word_nxt_c == quota_q) begin
                        rr_ptr_q <= ptr_nxt_c;
                        state_q  <= i_cfg_enable ? ST_ARB : ST_IDLE;
                     end else if (!i_cfg_enable) begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     beat_q <= beat_q + BW'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pbru_in_arb.sv
// Scoreboard bench for pbru_in_arb: a round-based reference schedule fills an
// expected-beat queue; a monitor pops and compares every aggregator write.
module tb_pbru_in_arb;

   localparam int unsigned NC = 4;
   localparam int unsigned IW = 16;
   localparam int unsigned SN = 4;
   localparam int unsigned WW = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NC-1:0]   i_ch_valid = '0;
   logic [NC*IW-1:0] i_ch_data = '0;
   logic [NC-1:0]   o_ch_ready;
   logic            i_cfg_enable = 1'b0;
   logic            i_cfg_mode = 1'b0;
   logic [NC*WW-1:0] i_cfg_weight = '0;
   logic            i_agg_full = 1'b0;
   logic            o_agg_wr_valid;
   logic [IW-1:0]   o_agg_data;
   logic [1:0]      o_grant_id;
   logic            o_busy;

   pbru_in_arb #(
      .NUM_CH(NC), .INPUT_WIDTH(IW), .SET_NUMBER(SN), .WEIGHT_WIDTH(WW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ch_valid(i_ch_valid), .i_ch_data(i_ch_data), .o_ch_ready(o_ch_ready),
      .i_cfg_enable(i_cfg_enable), .i_cfg_mode(i_cfg_mode), .i_cfg_weight(i_cfg_weight),
      .i_agg_full(i_agg_full), .o_agg_wr_valid(o_agg_wr_valid), .o_agg_data(o_agg_data),
      .o_grant_id(o_grant_id), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            ch;
      logic [IW-1:0] data;
   } exp_t;

   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int unsigned seed;
   int          rem[NC];
   int          idx[NC];
   int          plan_idx[NC];
   bit          extra_v[NC];
   bit          hold_off[NC];
   bit [NC-1:0] forbid = '0;
   bit          full_force = 1'b0;
   int          stall_pct = 0;
   int          hs = 0;
   int          mptr = 0;
   bit          cfg_en = 1'b0;
   bit          cfg_mode = 1'b0;
   logic [NC*WW-1:0] cfg_w = '0;
   exp_t        exp_q[$];
   int          xcyc[$];

   always @(posedge clk) cyc++;

   function automatic logic [IW-1:0] beat_data(input int c, input int k);
      int unsigned x;
      x = seed + 32'(c) * 32'd7919 + 32'(k) * 32'd40503;
      x = x ^ (x >> 11);
      return IW'(x);
   endfunction

   function automatic int rem_total();
      int s = 0;
      for (int c = 0; c < NC; c++) s += rem[c];
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_beats(input int c, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.ch   = c;
         e.data = beat_data(c, plan_idx[c]);
         plan_idx[c]++;
         exp_q.push_back(e);
      end
   endtask

   // Reference schedule: whole rounds over eligible active channels from the pointer.
   task automatic plan(input bit mode, input logic [NC*WW-1:0] w, input bit [NC-1:0] act,
                       input int rounds);
      int l[$];
      int q;
      for (int i = 0; i < NC; i++) begin
         int c;
         c = (mptr + i) % NC;
         if (act[c]) begin
            if (!mode || w[c*WW +: WW] != '0) l.push_back(c);
            else extra_v[c] = 1'b1;
         end
      end
      for (int r = 0; r < rounds; r++) begin
         foreach (l[j]) begin
            q = mode ? int'(w[l[j]*WW +: WW]) : 1;
            push_beats(l[j], q * SN);
            rem[l[j]] += q * SN;
         end
      end
      if (l.size() > 0) mptr = (l[l.size()-1] + 1) % NC;
   endtask

   task automatic step();
      logic [NC-1:0]    v;
      logic [NC*IW-1:0] d;
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
         v[c] = ((rem[c] > 0) || extra_v[c]) && !hold_off[c];
         d[c*IW +: IW] = beat_data(c, idx[c]);
      end
      i_ch_valid   = v;
      i_ch_data    = d;
      i_cfg_enable = cfg_en;
      i_cfg_mode   = cfg_mode;
      i_cfg_weight = cfg_w;
      i_agg_full   = full_force || (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
      #3;
      for (int c = 0; c < NC; c++) begin
         if (i_ch_valid[c] && o_ch_ready[c] && rst_n) begin
            idx[c]++;
            if (rem[c] > 0) rem[c]--;
            hs++;
         end
      end
      #1;
   endtask

   task automatic run_seg(input int bound, output int s);
      int n = 0;
      s = -1;
      do begin
         step();
         if (s < 0) s = cyc;
         n++;
      end while (!(exp_q.size() == 0 && !o_busy && rem_total() == 0) && n < bound);
      chk("seg_left", 64'(exp_q.size()), 0);
      chk("seg_busy", 64'(o_busy), 0);
      for (int c = 0; c < NC; c++) extra_v[c] = 1'b0;
   endtask

   task automatic step_until_hs(input int target, input string name);
      int n = 0;
      while (hs < target && n < 100) begin
         step();
         n++;
      end
      chk(name, 64'(hs), 64'(target));
   endtask

   // Monitor: checks every write against the scoreboard and ready legality each cycle.
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (rst_n) begin
         n_tests++;
         if (((o_ch_ready & ~(4'b0001 << o_grant_id)) != '0) || (!o_busy && o_ch_ready != '0)
             || (i_agg_full && o_ch_ready != '0) || ((o_ch_ready & forbid) != '0)) begin
            n_fail++;
            $display("FAIL ready_legal: ready=%b grant=%0d busy=%0b full=%0b", o_ch_ready,
                     o_grant_id, o_busy, i_agg_full);
         end
         if (o_agg_wr_valid) begin
            xcyc.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_xfer: ch %0d data %0h, none expected", o_grant_id,
                        o_agg_data);
            end else begin
               e = exp_q.pop_front();
               if (int'(o_grant_id) != e.ch || o_agg_data !== e.data) begin
                  n_fail++;
                  $display("FAIL xfer: got ch %0d data %0h expected ch %0d data %0h",
                           o_grant_id, o_agg_data, e.ch, e.data);
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int h0;
      int n;
      seed = $urandom;
      for (int c = 0; c < NC; c++) begin
         rem[c] = 0; idx[c] = 0; plan_idx[c] = 0; extra_v[c] = 1'b0; hold_off[c] = 1'b0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", 64'(o_ch_ready), 0);
      chk("rst_wr_valid", 64'(o_agg_wr_valid), 0);
      chk("rst_data", 64'(o_agg_data), 0);
      chk("rst_grant", 64'(o_grant_id), 0);
      chk("rst_busy", 64'(o_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cfg_en = 1'b1;

      // Round-robin, all valid: order, beat count and timing
      plan(1'b0, '0, 4'hF, 2);
      xcyc.delete();
      run_seg(400, s);
      chk("rr_count", 64'(xcyc.size()), 32);
      for (int i = 0; i < 32 && i < xcyc.size(); i++) begin
         chk("rr_timing", 64'(xcyc[i]), 64'(s + 2 + i + i / 4));
      end

      // Weighted {1,0,3,2}: ch1 valid but never readied
      cfg_mode = 1'b1;
      cfg_w = {4'd2, 4'd3, 4'd0, 4'd1};
      forbid = 4'b0010;
      plan(1'b1, cfg_w, 4'hF, 2);
      run_seg(400, s);
      forbid = '0;

      // Largest quota with random back-pressure
      cfg_w = {4'd0, 4'd0, 4'd15, 4'd0};
      stall_pct = 25;
      plan(1'b1, cfg_w, 4'b0010, 1);
      run_seg(600, s);
      stall_pct = 0;

      // Ch1 alone, aggregator full for 5 cycles mid-word
      cfg_mode = 1'b0;
      cfg_w = '0;
      h0 = hs;
      plan(1'b0, '0, 4'b0010, 1);
      step_until_hs(h0 + 2, "stall_pre");
      full_force = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_ready", 64'(o_ch_ready), 0);
         chk("stall_wr", 64'(o_agg_wr_valid), 0);
      end
      chk("stall_frozen", 64'(hs), 64'(h0 + 2));
      full_force = 1'b0;
      run_seg(50, s);
      chk("stall_total", 64'(hs), 64'(h0 + 4));

      // Ch3 drops valid for 10 cycles at beat 1; grant held, ch0 never readied
      h0 = hs;
      plan(1'b0, '0, 4'b1000, 1);
      extra_v[0] = 1'b1;
      forbid = 4'b0111;
      step_until_hs(h0 + 1, "hold_pre");
      hold_off[3] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_grant", 64'(o_grant_id), 3);
         chk("hold_others", 64'(o_ch_ready & 4'b0111), 0);
      end
      chk("hold_frozen", 64'(hs), 64'(h0 + 1));
      hold_off[3] = 1'b0;
      extra_v[0] = 1'b0;
      run_seg(50, s);
      forbid = '0;
      chk("hold_total", 64'(hs), 64'(h0 + 4));

      // Enable dropped after beat 2 of a weight-3 grant
      cfg_mode = 1'b1;
      cfg_w = {4'd0, 4'd0, 4'd0, 4'd3};
      h0 = hs;
      push_beats(0, 4);
      extra_v[0] = 1'b1;
      step_until_hs(h0 + 2, "endrop_pre");
      cfg_en = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (o_busy && n < 50);
      chk("endrop_busy", 64'(o_busy), 0);
      chk("endrop_beats", 64'(hs), 64'(h0 + 4));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("endrop_ready", 64'(o_ch_ready), 0);
      end
      chk("endrop_left", 64'(exp_q.size()), 0);
      extra_v[0] = 1'b0;
      step();
      cfg_en = 1'b1;

      // Reset pulse after beat 2 of ch2, then all valid restarts at ch0
      cfg_mode = 1'b0;
      cfg_w = '0;
      h0 = hs;
      push_beats(2, 2);
      extra_v[2] = 1'b1;
      step_until_hs(h0 + 2, "rstmid_pre");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_ready", 64'(o_ch_ready), 0);
      chk("rstmid_wr", 64'(o_agg_wr_valid), 0);
      chk("rstmid_data", 64'(o_agg_data), 0);
      chk("rstmid_grant", 64'(o_grant_id), 0);
      chk("rstmid_busy", 64'(o_busy), 0);
      extra_v[2] = 1'b0;
      step();
      @(negedge clk);
      rst_n = 1'b1;
      mptr = 0;
      xcyc.delete();
      plan(1'b0, '0, 4'hF, 1);
      run_seg(200, s);
      chk("rstmid_first", 64'(xcyc.size() > 0 ? xcyc[0] : -1), 64'(s + 2));

      // Weighted mode with every weight zero stays idle
      cfg_mode = 1'b1;
      cfg_w = '0;
      for (int c = 0; c < NC; c++) extra_v[c] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("zerow_idle", 64'(o_busy), 0);
      end
      for (int c = 0; c < NC; c++) extra_v[c] = 1'b0;

      // Randomized configurations, sets and back-pressure
      for (int seg = 0; seg < 10; seg++) begin
         cfg_mode = 1'($urandom_range(0, 1));
         for (int c = 0; c < NC; c++) cfg_w[c*WW +: WW] = WW'($urandom_range(0, 3));
         stall_pct = $urandom_range(0, 40);
         plan(cfg_mode, cfg_w, 4'($urandom_range(1, 15)), $urandom_range(1, 2));
         run_seg(2000, s);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
